// File: rtl/register_file_mp_if.sv
// Register-file bus: NUM_RD flat read ports, two write ports (W1 has priority), ready flag.
// The master drives addresses and writes; the slave returns read data and ready.
interface register_file_mp_if #(
  parameter int DATA_N = 32,
  parameter int SIZE   = 16,
  parameter int NUM_RD = 3
);
  localparam int AW = $clog2(SIZE);

  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_N-1:0] rd_data;
  logic                     w0_en;
  logic [AW-1:0]            w0_addr;
  logic [DATA_N-1:0]        w0_data;
  logic                     w1_en;
  logic [AW-1:0]            w1_addr;
  logic [DATA_N-1:0]        w1_data;
  logic                     ready;

  modport master (
    output rd_addr, w0_en, w0_addr, w0_data, w1_en, w1_addr, w1_data,
    input  rd_data, ready
  );

  modport slave (
    input  rd_addr, w0_en, w0_addr, w0_data, w1_en, w1_addr, w1_data,
    output rd_data, ready
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_RD zero-latency read ports, 2 write ports, W1 wins address clashes.
// Writes land next edge; after reset a SIZE-cycle sweep zeroes the array and writes are dropped until ready.
module register_file_mp #(
  parameter int DATA_N = 32,
  parameter int SIZE   = 16,
  parameter int NUM_RD = 3,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  register_file_mp_if.slave bus
);
  localparam int AW = $clog2(SIZE);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t            r_state;
  logic [AW-1:0]     r_clr_cnt;
  logic              r_ready;
  logic [DATA_N-1:0] r_regs [SIZE];

  // The array itself is not reset; the sweep zeroes one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_regs[r_clr_cnt] <= '0;
          r_clr_cnt         <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == AW'(SIZE - 1)) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.w0_en) r_regs[bus.w0_addr] <= bus.w0_data;
          if (bus.w1_en) r_regs[bus.w1_addr] <= bus.w1_data;
        end
        default: begin
          r_state   <= ST_CLEAR;
          r_clr_cnt <= '0;
          r_ready   <= 1'b0;
        end
      endcase
    end
  end

  logic [NUM_RD*DATA_N-1:0] w_rd_data;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [AW-1:0]     w_addr;
    logic [DATA_N-1:0] w_val;

    assign w_addr = bus.rd_addr[g*AW +: AW];

    always_comb begin
      w_val = r_regs[w_addr];
      if (BYPASS != 0) begin
        if (bus.w1_en && (bus.w1_addr == w_addr)) begin
          w_val = bus.w1_data;
        end else if (bus.w0_en && (bus.w0_addr == w_addr)) begin
          w_val = bus.w0_data;
        end
      end
      if (r_state != ST_RUN) w_val = '0;
    end

    assign w_rd_data[g*DATA_N +: DATA_N] = w_val;
  end

  assign bus.rd_data = w_rd_data;
  assign bus.ready   = r_ready;
endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: expected reads/ready pushed to a queue at drive time,
// popped and compared at the following negedge.
module tb_register_file_mp;
  localparam int DATA_N = 32;
  localparam int SIZE   = 16;
  localparam int NUM_RD = 3;
  localparam int AW     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  register_file_mp_if #(.DATA_N(DATA_N), .SIZE(SIZE), .NUM_RD(NUM_RD)) bus ();

  register_file_mp #(
    .DATA_N(DATA_N), .SIZE(SIZE), .NUM_RD(NUM_RD), .BYPASS(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string       tag;
    int          port;   // -1 selects ready
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl [SIZE];
  bit          model_run = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int port, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.port = port;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] observed(input int port);
    if (port < 0) return {31'b0, bus.ready};
    return bus.rd_data[port*DATA_N +: DATA_N];
  endfunction

  task automatic sample();
    exp_t e;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.tag, observed(e.port), e.val);
    end
  endtask

  // Model is updated with the writes present at the edge, then inputs may change.
  task automatic commit();
    if (model_run) begin
      if (bus.w0_en) mdl[bus.w0_addr] = bus.w0_data;
      if (bus.w1_en) mdl[bus.w1_addr] = bus.w1_data;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_rd(input int a);
    if (!model_run) return 32'h0;
    if (bus.w1_en && (bus.w1_addr == AW'(a))) return bus.w1_data;
    if (bus.w0_en && (bus.w0_addr == AW'(a))) return bus.w0_data;
    return mdl[a];
  endfunction

  task automatic set_rd(input int p, input int a);
    bus.rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_w0(input logic en, input int a, input logic [31:0] d);
    bus.w0_en = en; bus.w0_addr = AW'(a); bus.w0_data = d;
  endtask

  task automatic set_w1(input logic en, input int a, input logic [31:0] d);
    bus.w1_en = en; bus.w1_addr = AW'(a); bus.w1_data = d;
  endtask

  // n sweep cycles with ready low and all reads forced to zero.
  task automatic clear_cycles(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      push({tag, "_rdy0"}, -1, 32'h0);
      for (int p = 0; p < NUM_RD; p++) push({tag, "_rd0"}, p, 32'h0);
      sample();
      commit();
    end
  endtask

  // Called right after the 16th sweep edge: ready must be up and every register zero.
  task automatic post_sweep(input string tag);
    set_w0(1'b0, 0, 32'h0);
    set_w1(1'b0, 0, 32'h0);
    model_run = 1'b1;
    for (int i = 0; i < SIZE; i++) mdl[i] = 32'h0;
    push({tag, "_rdy1"}, -1, 32'h1);
    for (int b = 0; b < SIZE; b += NUM_RD) begin
      for (int p = 0; p < NUM_RD; p++) begin
        set_rd(p, (b + p) % SIZE);
        push({tag, "_zero"}, p, 32'h0);
      end
      sample();
      commit();
    end
  endtask

  initial begin
    bus.rd_addr = '0;
    set_w0(1'b1, 0, 32'h55);
    set_w1(1'b1, 1, 32'h66);
    set_rd(0, 0); set_rd(1, 1); set_rd(2, 2);

    // 1: reset then sweep with writes held on; they must not land.
    rst = 1'b1;
    commit();
    rst = 1'b0;
    clear_cycles("t1", SIZE);
    post_sweep("t1");

    // 2: W0 write with same-cycle bypass, then array read.
    set_w0(1'b1, 3, 32'hDEADBEEF);
    set_rd(0, 3);
    push("t2_byp", 0, 32'hDEADBEEF);
    sample();
    commit();
    set_w0(1'b0, 0, 32'h0);
    push("t2_arr", 0, 32'hDEADBEEF);
    sample();

    // 3: both ports hit r5; W1 wins.
    set_w0(1'b1, 5, 32'h11);
    set_w1(1'b1, 5, 32'h22);
    set_rd(0, 5);
    push("t3_byp", 0, 32'h22);
    sample();
    commit();
    set_w0(1'b0, 0, 32'h0);
    set_w1(1'b0, 0, 32'h0);
    push("t3_arr", 0, 32'h22);
    sample();

    // 4: independent writes, shared read addresses; port 2 first sees unrelated r3.
    set_w0(1'b1, 1, 32'hA);
    set_w1(1'b1, 2, 32'hB);
    set_rd(0, 1); set_rd(1, 2); set_rd(2, 3);
    push("t4_byp0", 0, 32'hA);
    push("t4_byp1", 1, 32'hB);
    push("t4_old3", 2, 32'hDEADBEEF);
    sample();
    commit();
    set_w0(1'b0, 0, 32'h0);
    set_w1(1'b0, 0, 32'h0);
    set_rd(2, 2);
    push("t4_arr0", 0, 32'hA);
    push("t4_arr1", 1, 32'hB);
    push("t4_arr2", 2, 32'hB);
    sample();
    commit();

    // Random traffic checked against the model.
    for (int c = 0; c < 40; c++) begin
      set_w0($urandom_range(0, 1) == 1, $urandom_range(0, SIZE-1), $urandom);
      set_w1($urandom_range(0, 3) == 0, $urandom_range(0, SIZE-1), $urandom);
      for (int p = 0; p < NUM_RD; p++) begin
        set_rd(p, $urandom_range(0, SIZE-1));
        push("rnd", p, exp_rd(int'(bus.rd_addr[p*AW +: AW])));
      end
      sample();
      commit();
    end

    // 5: reset at sweep cycle 8 with W0 held on r15; sweep restarts from zero.
    set_w0(1'b1, 15, 32'hBAD0BAD0);
    set_w1(1'b0, 0, 32'h0);
    model_run = 1'b0;
    rst = 1'b1;
    commit();
    rst = 1'b0;
    clear_cycles("t5a", 8);
    rst = 1'b1;
    commit();
    rst = 1'b0;
    clear_cycles("t5b", SIZE);
    post_sweep("t5");

    // 6: fill every register with nonzero data, then reset and sweep.
    for (int i = 0; i < SIZE; i += 2) begin
      set_w0(1'b1, i, 32'h1000 + i);
      set_w1(1'b1, i + 1, 32'h2000 + i);
      commit();
    end
    set_w0(1'b0, 0, 32'h0);
    set_w1(1'b0, 0, 32'h0);
    set_rd(0, 7);
    push("t6_fill", 0, 32'h2006);
    sample();
    model_run = 1'b0;
    rst = 1'b1;
    commit();
    rst = 1'b0;
    clear_cycles("t6", SIZE);
    post_sweep("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
